// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock over N+1 iterations,
// with a start/busy/done handshake and a registered 2N-bit product.
module booth_seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Z
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [W-1:0]  a_q, a_d;
  logic        [W-1:0]  qr_q, qr_d;
  logic                 q1_q, q1_d;
  logic signed [W-1:0]  mr_q, mr_d;
  logic        [CW-1:0] cnt_q, cnt_d;
  logic        [2*N-1:0] z_q, z_d;
  logic signed [W-1:0]  a_sum;
  logic                 accept;

  // One extra bit lets unsigned operands be treated as non-negative signed values.
  function automatic logic signed [W-1:0] ext_op(input logic [N-1:0] op, input logic sgn);
    return sgn ? {op[N-1], op} : {1'b0, op};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      q1_q    <= 1'b0;
      mr_q    <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      q1_q    <= q1_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    q1_d    = q1_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    a_sum   = a_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;

    case (state_q)
      IDLE: accept = start;
      RUN: begin
        busy = 1'b1;
        case ({qr_q[0], q1_q})
          2'b01:   a_sum = a_q + mr_q;
          2'b10:   a_sum = a_q - mr_q;
          default: a_sum = a_q;
        endcase
        // Arithmetic shift right of the {A, QR, q_1} chain.
        a_d   = {a_sum[W-1], a_sum[W-1:1]};
        qr_d  = {a_sum[0], qr_q[W-1:1]};
        q1_d  = qr_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          z_d     = {a_d[N-2:0], qr_d};
          state_d = DONE;
        end
      end
      DONE: begin
        done   = 1'b1;
        accept = start;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      mr_d    = ext_op(M, is_signed);
      qr_d    = ext_op(Q, is_signed);
      a_d     = '0;
      q1_d    = 1'b0;
      cnt_d   = CNT_INIT;
      state_d = RUN;
    end
  end

  assign Z = z_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier with N=4 and N=8 instances and a result scoreboard.
module tb_booth_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0, sg4 = 1'b0;
  logic [3:0] m4 = '0, q4 = '0;
  logic       busy4, done4;
  logic [7:0] z4;

  logic       start8 = 1'b0, sg8 = 1'b0;
  logic [7:0] m8 = '0, q8 = '0;
  logic       busy8, done8;
  logic [15:0] z8;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  sb4[$];
  logic [15:0] sb8[$];

  booth_seq_multiplier #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .is_signed(sg4),
    .M(m4), .Q(q4), .busy(busy4), .done(done4), .Z(z4)
  );

  booth_seq_multiplier #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .is_signed(sg8),
    .M(m8), .Q(q8), .busy(busy8), .done(done8), .Z(z8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after acceptance; returns at the done negedge or on timeout.
  task automatic wait4(output int nc, output int nb);
    nc = 0;
    nb = 0;
    while (done4 !== 1'b1 && nc < 20) begin
      if (busy4 === 1'b1) nb++;
      nc++;
      @(negedge clk);
    end
  endtask

  task automatic op4(input string tag, input logic [3:0] m, input logic [3:0] q,
                     input logic s, input logic [7:0] exp);
    int nc, nb;
    logic [7:0] e;
    m4 = m; q4 = q; sg4 = s; start4 = 1'b1;
    sb4.push_back(exp);
    @(negedge clk);
    start4 = 1'b0;
    wait4(nc, nb);
    chk({tag, " latency"}, nc, 5);
    chk({tag, " busy cycles"}, nb, 5);
    e = sb4.pop_front();
    chk({tag, " Z"}, z4, e);
    chk({tag, " busy at done"}, busy4, 1'b0);
    @(negedge clk);
    chk({tag, " done one cycle"}, done4, 1'b0);
    chk({tag, " Z held"}, z4, e);
  endtask

  task automatic op8(input string tag, input logic [7:0] m, input logic [7:0] q,
                     input logic s, input logic [15:0] exp);
    int nc;
    logic [15:0] e;
    m8 = m; q8 = q; sg8 = s; start8 = 1'b1;
    sb8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
    nc = 0;
    while (done8 !== 1'b1 && nc < 30) begin
      nc++;
      @(negedge clk);
    end
    chk({tag, " latency"}, nc, 9);
    e = sb8.pop_front();
    chk({tag, " Z"}, z8, e);
  endtask

  initial begin
    int nc, nb, t1, t2, t3, seen;
    logic [7:0] e;

    repeat (2) @(negedge clk);
    chk("reset busy4", busy4, 1'b0);
    chk("reset done4", done4, 1'b0);
    chk("reset Z4", z4, 8'h00);
    chk("reset Z8", z8, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    op4("s 4*3", 4'd4, 4'd3, 1'b1, 8'h0C);
    op4("s -7*4", 4'h9, 4'h4, 1'b1, 8'hE4);
    op4("s 5*-8", 4'h5, 4'h8, 1'b1, 8'hD8);
    op4("s -6*-7", 4'hA, 4'h9, 1'b1, 8'h2A);
    op4("s 7*-8", 4'h7, 4'h8, 1'b1, 8'hC8);
    op4("u 15*15", 4'hF, 4'hF, 1'b0, 8'hE1);
    op4("s -1*-1", 4'hF, 4'hF, 1'b1, 8'h01);

    op8("s8 -128*-128", 8'h80, 8'h80, 1'b1, 16'h4000);
    op8("u8 255*255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);

    // start held high: operands changed mid-run become the next request only.
    m4 = 4'd3; q4 = 4'd5; sg4 = 1'b1; start4 = 1'b1;
    sb4.push_back(8'h0F);
    @(negedge clk);
    m4 = 4'hE; q4 = 4'd7;
    sb4.push_back(8'hF2);
    wait4(nc, nb);
    chk("b2b1 latency", nc, 5);
    e = sb4.pop_front();
    chk("b2b1 Z", z4, e);
    t1 = cyc;
    @(negedge clk);
    m4 = 4'h9; q4 = 4'd3;
    sb4.push_back(8'hEB);
    wait4(nc, nb);
    e = sb4.pop_front();
    chk("b2b2 Z", z4, e);
    t2 = cyc;
    chk("b2b2 spacing", t2 - t1, 6);
    @(negedge clk);
    start4 = 1'b0; m4 = 4'h0; q4 = 4'h0;
    wait4(nc, nb);
    e = sb4.pop_front();
    chk("b2b3 Z", z4, e);
    t3 = cyc;
    chk("b2b3 spacing", t3 - t2, 6);
    @(negedge clk);
    chk("b2b idle done", done4, 1'b0);
    chk("b2b idle busy", busy4, 1'b0);
    chk("scoreboard empty", sb4.size(), 0);

    // Asynchronous abort in the middle of an operation.
    m4 = 4'd5; q4 = 4'd3; sg4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    chk("abort pre busy", busy4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy4, 1'b0);
    chk("abort done", done4, 1'b0);
    chk("abort Z", z4, 8'h00);
    chk("abort Z8", z8, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 === 1'b1) seen++;
    end
    chk("abort no done", seen, 0);
    op4("post-reset 6*5", 4'd6, 4'd5, 1'b1, 8'h1E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
